// File: rtl/rfsb_pkg.sv
// Shared definitions for the register-file scoreboard: condition-code
// encodings and the helper that derives N/Z/P from writeback data.
package rfsb_pkg;

   localparam logic [2:0] CC_N     = 3'b100;
   localparam logic [2:0] CC_Z     = 3'b010;
   localparam logic [2:0] CC_P     = 3'b001;
   localparam logic [2:0] CC_RESET = CC_Z;

   // Sign bit and all-zero flag are enough to classify a signed value.
   function automatic logic [2:0] cc_from_sign(input logic is_neg, input logic is_zero);
      if (is_neg)
         return CC_N;
      else if (is_zero)
         return CC_Z;
      else
         return CC_P;
   endfunction

endpackage

// File: rtl/pend_counter.sv
// Per-register count of in-flight writes. Decrement saturates at zero and
// reports the attempt through 'underflow'.
module pend_counter #(
   parameter int PEND_WIDTH = 2
) (
   input  logic                  I_CLOCK,
   input  logic                  I_RESET,
   input  logic                  inc,
   input  logic                  dec,
   output logic [PEND_WIDTH-1:0] count,
   output logic                  zero,
   output logic                  one,
   output logic                  sat,
   output logic                  underflow
);

   localparam logic [PEND_WIDTH-1:0] COUNT_MAX = '1;
   localparam logic [PEND_WIDTH-1:0] COUNT_ONE = PEND_WIDTH'(1);

   logic dec_ok;

   assign zero      = (count == '0);
   assign one       = (count == COUNT_ONE);
   assign sat       = (count == COUNT_MAX);
   assign dec_ok    = dec & ~zero;
   assign underflow = dec & zero;

   // An issue and a retiring writeback in the same cycle cancel out.
   always_ff @(posedge I_CLOCK) begin
      if (I_RESET)
         count <= '0;
      else if (inc && !dec_ok)
         count <= count + 1'b1;
      else if (!inc && dec_ok)
         count <= count - 1'b1;
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with per-register pending-write counters and
// N/Z/P condition code. Define RFSB_BYPASS_EN to forward writeback data.
module regfile_scoreboard
   import rfsb_pkg::*;
#(
   parameter  int NUM_REGS   = 16,
   parameter  int REG_WIDTH  = 16,
   parameter  int PEND_WIDTH = 2,
   localparam int IDX_W      = $clog2(NUM_REGS)
) (
   input  logic                 I_CLOCK,
   input  logic                 I_RESET,
   input  logic                 I_IssueValid,
   input  logic                 I_Src1Used,
   input  logic                 I_Src2Used,
   input  logic [IDX_W-1:0]     I_Src1Idx,
   input  logic [IDX_W-1:0]     I_Src2Idx,
   input  logic                 I_DestUsed,
   input  logic [IDX_W-1:0]     I_DestIdx,
   input  logic                 I_WbEnable,
   input  logic [IDX_W-1:0]     I_WbIdx,
   input  logic [REG_WIDTH-1:0] I_WbData,
   output logic                 O_Issue,
   output logic                 O_DepStall,
   output logic [REG_WIDTH-1:0] O_Src1Value,
   output logic [REG_WIDTH-1:0] O_Src2Value,
   output logic [2:0]           O_CondCode,
   output logic                 O_WbUnderflow
);

   logic [REG_WIDTH-1:0] rf [NUM_REGS];

   logic [NUM_REGS-1:0][PEND_WIDTH-1:0] pend_count;
   logic [NUM_REGS-1:0] pend_inc, pend_dec;
   logic [NUM_REGS-1:0] pend_zero, pend_one, pend_sat, pend_uf;

   logic src1_bypass, src2_bypass;
   logic src1_hazard, src2_hazard, dest_hazard;

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
      assign pend_inc[r] = O_Issue & I_DestUsed & (I_DestIdx == IDX_W'(r));
      assign pend_dec[r] = I_WbEnable & (I_WbIdx == IDX_W'(r));

      pend_counter #(.PEND_WIDTH(PEND_WIDTH)) u_pend (
         .I_CLOCK   (I_CLOCK),
         .I_RESET   (I_RESET),
         .inc       (pend_inc[r]),
         .dec       (pend_dec[r]),
         .count     (pend_count[r]),
         .zero      (pend_zero[r]),
         .one       (pend_one[r]),
         .sat       (pend_sat[r]),
         .underflow (pend_uf[r])
      );
   end

   // Raw counts are kept for hierarchical debug; the 'one' flags are only
   // consumed when forwarding is built in.
   logic unused_pend;
   assign unused_pend = ^{pend_count, pend_one};

   // Issue decision and operand read. Forwarding only applies when the
   // writeback in flight is the last outstanding write to that source.
   always_comb begin
      src1_bypass = 1'b0;
      src2_bypass = 1'b0;
`ifdef RFSB_BYPASS_EN
      src1_bypass = I_WbEnable & (I_WbIdx == I_Src1Idx) & pend_one[I_Src1Idx];
      src2_bypass = I_WbEnable & (I_WbIdx == I_Src2Idx) & pend_one[I_Src2Idx];
`endif
      src1_hazard = I_Src1Used & ~pend_zero[I_Src1Idx] & ~src1_bypass;
      src2_hazard = I_Src2Used & ~pend_zero[I_Src2Idx] & ~src2_bypass;
      dest_hazard = I_DestUsed & pend_sat[I_DestIdx];

      O_Issue     = I_IssueValid & ~src1_hazard & ~src2_hazard & ~dest_hazard;
      O_DepStall  = I_IssueValid & ~O_Issue;
      O_Src1Value = src1_bypass ? I_WbData : rf[I_Src1Idx];
      O_Src2Value = src2_bypass ? I_WbData : rf[I_Src2Idx];
   end

   // Writeback always lands, even without a pending write; that case is
   // flagged as a sticky underflow.
   always_ff @(posedge I_CLOCK) begin
      if (I_RESET) begin
         for (int i = 0; i < NUM_REGS; i++)
            rf[i] <= '0;
         O_CondCode    <= CC_RESET;
         O_WbUnderflow <= 1'b0;
      end else if (I_WbEnable) begin
         rf[I_WbIdx] <= I_WbData;
         O_CondCode  <= cc_from_sign(I_WbData[REG_WIDTH-1], I_WbData == '0);
         if (|pend_uf)
            O_WbUnderflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: a behavioural scoreboard model
// checked every cycle, plus directed literal expectations.
module tb_regfile_scoreboard;

   localparam int NUM_REGS   = 16;
   localparam int REG_WIDTH  = 16;
   localparam int PEND_WIDTH = 2;
   localparam int IDX_W      = $clog2(NUM_REGS);
   localparam int PEND_MAX   = (1 << PEND_WIDTH) - 1;
`ifdef RFSB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic                 I_CLOCK = 1'b0;
   logic                 I_RESET = 1'b1;
   logic                 I_IssueValid = 1'b0;
   logic                 I_Src1Used = 1'b0, I_Src2Used = 1'b0;
   logic [IDX_W-1:0]     I_Src1Idx = '0, I_Src2Idx = '0;
   logic                 I_DestUsed = 1'b0;
   logic [IDX_W-1:0]     I_DestIdx = '0;
   logic                 I_WbEnable = 1'b0;
   logic [IDX_W-1:0]     I_WbIdx = '0;
   logic [REG_WIDTH-1:0] I_WbData = '0;
   logic                 O_Issue, O_DepStall;
   logic [REG_WIDTH-1:0] O_Src1Value, O_Src2Value;
   logic [2:0]           O_CondCode;
   logic                 O_WbUnderflow;

   int totalCount = 0;
   int badCount   = 0;

   regfile_scoreboard #(
      .NUM_REGS(NUM_REGS), .REG_WIDTH(REG_WIDTH), .PEND_WIDTH(PEND_WIDTH)
   ) dut (
      .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_IssueValid(I_IssueValid),
      .I_Src1Used(I_Src1Used), .I_Src2Used(I_Src2Used),
      .I_Src1Idx(I_Src1Idx), .I_Src2Idx(I_Src2Idx),
      .I_DestUsed(I_DestUsed), .I_DestIdx(I_DestIdx),
      .I_WbEnable(I_WbEnable), .I_WbIdx(I_WbIdx), .I_WbData(I_WbData),
      .O_Issue(O_Issue), .O_DepStall(O_DepStall),
      .O_Src1Value(O_Src1Value), .O_Src2Value(O_Src2Value),
      .O_CondCode(O_CondCode), .O_WbUnderflow(O_WbUnderflow)
   );

   always #5 I_CLOCK = ~I_CLOCK;

   // Architectural model: plain arrays of values and outstanding-write counts.
   int   modelRf   [NUM_REGS];
   int   modelPend [NUM_REGS];
   logic [2:0] modelCc = 3'b010;
   bit   modelUf = 1'b0;
   bit   checkEn = 1'b0;

   function automatic bit modelForward(input int src);
      return BYPASS && I_WbEnable && (int'(I_WbIdx) == src) && (modelPend[src] == 1);
   endfunction

   function automatic bit modelIssue();
      bit blocked;
      blocked = 1'b0;
      if (I_Src1Used && modelPend[I_Src1Idx] > 0 && !modelForward(int'(I_Src1Idx))) blocked = 1'b1;
      if (I_Src2Used && modelPend[I_Src2Idx] > 0 && !modelForward(int'(I_Src2Idx))) blocked = 1'b1;
      if (I_DestUsed && modelPend[I_DestIdx] == PEND_MAX) blocked = 1'b1;
      return I_IssueValid && !blocked;
   endfunction

   function automatic int modelRead(input int src);
      return modelForward(src) ? int'(I_WbData) : modelRf[src];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalCount++;
      if (actual !== expected) begin
         badCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   initial begin
      for (int i = 0; i < NUM_REGS; i++) begin
         modelRf[i]   = 0;
         modelPend[i] = 0;
      end
   end

   // Model advances on the same edge as the DUT, from the pre-edge inputs.
   always @(posedge I_CLOCK) begin
      if (I_RESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            modelRf[i]   = 0;
            modelPend[i] = 0;
         end
         modelCc = 3'b010;
         modelUf = 1'b0;
         checkEn = 1'b1;
      end else begin
         bit issueNow;
         bit retire;
         issueNow = modelIssue();
         retire   = I_WbEnable && modelPend[I_WbIdx] > 0;
         if (I_WbEnable && modelPend[I_WbIdx] == 0) modelUf = 1'b1;
         if (issueNow && I_DestUsed) modelPend[I_DestIdx] = modelPend[I_DestIdx] + 1;
         if (retire) modelPend[I_WbIdx] = modelPend[I_WbIdx] - 1;
         if (I_WbEnable) begin
            modelRf[I_WbIdx] = int'(I_WbData);
            if ($signed(I_WbData) < 0)       modelCc = 3'b100;
            else if (I_WbData == '0)         modelCc = 3'b010;
            else                             modelCc = 3'b001;
         end
      end
   end

   // Every-cycle comparison; read data only matters when the issue goes out.
   always @(negedge I_CLOCK) begin
      if (checkEn && !I_RESET) begin
         bit expIssue;
         expIssue = modelIssue();
         checkOutput("issue", 32'(O_Issue), 32'(expIssue));
         checkOutput("depstall", 32'(O_DepStall), 32'(I_IssueValid && !expIssue));
         checkOutput("condcode", 32'(O_CondCode), 32'(modelCc));
         checkOutput("underflow", 32'(O_WbUnderflow), 32'(modelUf));
         if (expIssue && I_Src1Used)
            checkOutput("src1", 32'(O_Src1Value), 32'(modelRead(int'(I_Src1Idx))));
         if (expIssue && I_Src2Used)
            checkOutput("src2", 32'(O_Src2Value), 32'(modelRead(int'(I_Src2Idx))));
      end
   end

   task automatic applyStimulus(
      input bit rst, input bit iv,
      input bit s1u, input int s1, input bit s2u, input int s2,
      input bit du, input int d,
      input bit wbe, input int wbi, input logic [REG_WIDTH-1:0] wbd);
      @(posedge I_CLOCK);
      #1;
      I_RESET      = rst;
      I_IssueValid = iv;
      I_Src1Used   = s1u;  I_Src1Idx = IDX_W'(s1);
      I_Src2Used   = s2u;  I_Src2Idx = IDX_W'(s2);
      I_DestUsed   = du;   I_DestIdx = IDX_W'(d);
      I_WbEnable   = wbe;  I_WbIdx   = IDX_W'(wbi);
      I_WbData     = wbd;
      @(negedge I_CLOCK);
      #1;
   endtask

   initial begin
      #20000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);

      // Reset state: free registers read as zero, CC=Z, no underflow.
      applyStimulus(0, 1, 1, 7, 1, 9, 0, 0, 0, 0, 16'h0000);
      checkOutput("rst_issue", 32'(O_Issue), 32'd1);
      checkOutput("rst_src1", 32'(O_Src1Value), 32'h0);
      checkOutput("rst_cc", 32'(O_CondCode), 32'b010);
      checkOutput("rst_uf", 32'(O_WbUnderflow), 32'd0);

      // Basic issue and read: unsolicited writeback then read it back.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 16'h0005);
      applyStimulus(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 16'h0000);
      checkOutput("basic_uf", 32'(O_WbUnderflow), 32'd1);
      checkOutput("basic_cc", 32'(O_CondCode), 32'b001);
      checkOutput("basic_issue", 32'(O_Issue), 32'd1);
      checkOutput("basic_src1", 32'(O_Src1Value), 32'h5);

      // RAW stall on R2 until its writeback.
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 16'h0000);
      checkOutput("raw_dest_issue", 32'(O_Issue), 32'd1);
      applyStimulus(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 16'h0000);
      checkOutput("raw_stall1", 32'(O_DepStall), 32'd1);
      applyStimulus(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 16'h0000);
      checkOutput("raw_stall2", 32'(O_DepStall), 32'd1);
      applyStimulus(0, 1, 1, 2, 0, 0, 0, 0, 1, 2, 16'hFFFF);
      checkOutput("raw_wb_issue", 32'(O_Issue), 32'(BYPASS));
      if (O_Issue) checkOutput("raw_wb_fwd", 32'(O_Src1Value), 32'hFFFF);
      applyStimulus(0, 1, 1, 2, 1, 3, 0, 0, 0, 0, 16'h0000);
      checkOutput("raw_after_issue", 32'(O_Issue), 32'd1);
      checkOutput("raw_after_src1", 32'(O_Src1Value), 32'hFFFF);
      checkOutput("raw_after_src2", 32'(O_Src2Value), 32'h0005);
      checkOutput("raw_cc", 32'(O_CondCode), 32'b100);

      // Saturation: three in-flight writes to R4, the fourth stalls.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 16'h0000);
         checkOutput("sat_accept", 32'(O_Issue), 32'd1);
      end
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 16'h0000);
      checkOutput("sat_stall", 32'(O_Issue), 32'd0);
      checkOutput("sat_model_pend", 32'(modelPend[4]), 32'd3);

      // Simultaneous increment and decrement on R5.
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 16'h0000);
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 5, 1, 5, 16'h0000);
      checkOutput("incdec_issue", 32'(O_Issue), 32'd1);
      applyStimulus(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 16'h0000);
      checkOutput("incdec_stall", 32'(O_DepStall), 32'd1);
      checkOutput("incdec_cc", 32'(O_CondCode), 32'b010);
      checkOutput("incdec_model_pend", 32'(modelPend[5]), 32'd1);

      // WAW on R6: forwarding must not fire while two writes are in flight.
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 6, 0, 0, 16'h0000);
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 6, 0, 0, 16'h0000);
      applyStimulus(0, 1, 0, 0, 1, 6, 0, 0, 1, 6, 16'h1111);
      checkOutput("waw_stall", 32'(O_DepStall), 32'd1);

      // Mid-operation reset with R1 holding data and two pending writes.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h1234);
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0000);
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0000);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0007);
      applyStimulus(0, 1, 1, 1, 1, 4, 0, 0, 0, 0, 16'h0000);
      checkOutput("reset_issue", 32'(O_Issue), 32'd1);
      checkOutput("reset_src1", 32'(O_Src1Value), 32'h0);
      checkOutput("reset_src2", 32'(O_Src2Value), 32'h0);
      checkOutput("reset_cc", 32'(O_CondCode), 32'b010);
      checkOutput("reset_uf", 32'(O_WbUnderflow), 32'd0);

      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file with a counting scoreboard for the decode stage. It is the successor to the valid-bit decode register file. It provides two combinational read ports and one writeback port, tracks up to 2^PEND_WIDTH-1 in-flight writes per register instead of a single valid bit, and maintains the N/Z/P condition code. It decides each cycle whether the instruction presented by decode may issue, or must raise a dependency stall toward fetch.

## Interface
- NUM_REGS, 16, number of architectural registers; power of two, at least 2.
- REG_WIDTH, 16, data width of each register, in bits.
- PEND_WIDTH, 2, width of each per-register pending counter; maximum in-flight writes per register is 2^PEND_WIDTH-1.
- IDX_W (localparam) equals $clog2(NUM_REGS).

Ports:
- I_CLOCK  in  1  sole clock; all state updates on posedge.
- I_RESET  in  1  synchronous, active-high reset.
- I_IssueValid  in  1  decode presents an instruction this cycle.
- I_Src1Used, I_Src2Used  in  1 each  the source operand is read.
- I_Src1Idx, I_Src2Idx  in  IDX_W each  source register indices.
- I_DestUsed  in  1  the instruction writes a register.
- I_DestIdx  in  IDX_W  destination register index.
- I_WbEnable  in  1  writeback valid this cycle.
- I_WbIdx  in  IDX_W  writeback register index.
- I_WbData  in  REG_WIDTH  writeback data, treated as signed.
- O_Issue  out  1  combinational; instruction accepted this cycle.
- O_DepStall  out  1  combinational; equals I_IssueValid & !O_Issue.
- O_Src1Value, O_Src2Value  out  REG_WIDTH each  combinational read data.
- O_CondCode  out  3  registered {N,Z,P}.
- O_WbUnderflow  out  1  registered, sticky; set when a writeback targets a register whose pending count is 0.

## Operation
- **Source hazard.** SrcN is hazardous when SrcN_Used is asserted and pend[SrcN_Idx] != 0. The bypass exception (see Configuration) clears the hazard.
- **Destination hazard.** The destination is hazardous when DestUsed is asserted and pend[DestIdx] equals 2^PEND_WIDTH-1 (saturated). The writeback-decrement exception does not apply to the destination hazard.
- **Issue condition.** O_Issue = I_IssueValid & no Src1 hazard & no Src2 hazard & no destination hazard.
- **Write-after-write.** WAW is permitted; the counter accumulates the outstanding writes.
- **Posedge update, pending counters.** For each register r, the counter is incremented when O_Issue & I_DestUsed & DestIdx==r. It is decremented when I_WbEnable & WbIdx==r & pend[r]!=0. When both occur in the same cycle the count is unchanged.
- **Posedge update, data and flags.**
  - On I_WbEnable, RF[WbIdx] takes I_WbData.
  - O_CondCode takes 3'b100 if the data is negative (signed), 3'b010 if it is zero, and 3'b001 if it is positive.
  - A writeback with pend==0 still writes the data and the condition code, leaves the counter at 0, and sets O_WbUnderflow.
- **Read data.** Read data is RF[idx], subject to the bypass mux when it is compiled in. It is valid only when O_Issue is asserted.
- **Register 0.** Register 0 is an ordinary register.

## Timing
- Issue decision and read data are combinational; they have zero latency from the inputs.
- State (RF, pending counters, O_CondCode, O_WbUnderflow) changes only at posedge.
- Reset values:
  - all RF entries are 0;
  - all pending counters are 0;
  - O_CondCode is 3'b010;
  - O_WbUnderflow is 0.
- Combinational outputs follow the reset state in the cycle after the reset edge.
- Reset has priority over a simultaneous issue or writeback; in-flight writes are forgotten.
- After a writeback at edge k, a dependent instruction issues in the cycle after edge k. With bypass it issues in the same cycle as the writeback.

## Configuration
- **RFSB_BYPASS_EN defined.**
  - A source hazard is waived when I_WbEnable & WbIdx==SrcN_Idx & pend[SrcN_Idx]==1.
  - The corresponding O_SrcNValue then returns I_WbData instead of RF.
- **RFSB_BYPASS_EN undefined.** Any nonzero pending count stalls, and read data always comes from RF.

## Structure
- **Shared package rfsb_pkg** holds:
  - the condition code constants CC_N=3'b100, CC_Z=3'b010 and CC_P=3'b001;
  - the CC reset value CC_RESET equal to CC_Z.
- **Sub-module pend_counter** (parameter PEND_WIDTH), instantiated NUM_REGS times:
  - inputs are inc, dec and sync reset;
  - outputs are count, zero, one and sat;
  - its decrement saturates at 0 and it reports the underflow attempt.
- **Top level** holds the RF array, the hazard logic, the bypass muxes and the CC register.

## Test plan
- **Basic issue and read.** Reset, then writeback R3=16'h0005 with pend 0. Expect O_WbUnderflow=1 and O_CondCode=3'b001. Next cycle, issue with Src1=R3. Expect O_Issue=1 and O_Src1Value=5.
- **RAW stall.** Issue dest R2, then issue src R2. Expect O_DepStall=1 on every cycle until the writeback of R2=16'hFFFF. With bypass, issue is in the writeback cycle with value FFFF; without bypass, issue is one cycle later. O_CondCode=3'b100.
- **Saturation.** Defaults (PEND_WIDTH=2). Three issues with dest R4 and no writeback are accepted. Expect the 4th issue stalled (O_Issue=0) and pend[R4]=3.
- **Simultaneous inc/dec.** Hold pend[R5]=1. In one cycle, issue dest R5 and writeback R5=0. Expect pend to remain 1, O_CondCode=3'b010, and src R5 to still stall the following cycle.
- **WAW plus bypass.** Hold pend[R6]=2 and writeback R6 while src R6 is presented. Expect a stall even with bypass (count is not 1).
- **Mid-operation reset.** Hold pend[R1]=2, assert I_RESET together with a writeback. Expect all counters 0, RF[R1]=0, O_CondCode=3'b010, O_WbUnderflow=0, and src R1 issuing the next cycle.
